l1_dcache_nway: RTL and testbench
=================================

# l1_dcache_nway

Parametrised N-way set-associative, write-back, write-allocate L1 data cache that sits in the MEM stage, between the pipeline's data-memory request signals and the external 256-bit line-oriented memory port. It generalises the direct-mapped L1 data cache in three ways: configurable ways, sets and line width; round-robin victim selection; and an explicit flush command that writes back every dirty line. The pipeline stalls while `cache_cs && !cache_ack`.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `WORD_W`, 32, CPU word width; must be 32
- `LINE_W`, 256, line width in bits, equal to the external data bus width; power of two, multiple of `WORD_W`
- `SETS`, 32, number of sets; power of two, ≥2
- `WAYS`, 2, associativity; power of two, 1..8

Ports:
- `clk` in 1: single clock, all state updates on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `cache_addr` in `ADDR_W`: byte address; bits [1:0] ignored
- `cache_cs` in 1: request; held high with stable addr/we/data until `cache_ack`
- `cache_we` in 1: 1 = write word, 0 = read word
- `cache_data_i` in `WORD_W`: write data
- `cache_data_o` out `WORD_W`: read data, valid only in the `cache_ack` cycle
- `cache_ack` out 1: one-cycle completion pulse
- `flush_req` in 1: level request to write back all dirty lines
- `flush_done` out 1: one-cycle pulse when the flush completes
- `dram_addr` out `ADDR_W`: line-aligned address (low log2(`LINE_W`/8) bits zero)
- `dram_cs` out 1: external request; held until `dram_ack`
- `dram_we` out 1: 1 = line write-back, 0 = line fill
- `dram_data_o` out `LINE_W`: write-back line
- `dram_data_i` in `LINE_W`: fill line, sampled in the `dram_ack` cycle
- `dram_ack` in 1: one-cycle external completion

## Operation
- Address split: OFF = log2(`LINE_W`/8), IDX = log2(`SETS`). Word select = addr[OFF-1:2]. Index = addr[OFF+IDX-1:OFF]. Tag = remaining upper bits.
- Per way and per set, the cache stores valid, dirty, tag and data line. Each set has a log2(`WAYS`)-bit victim pointer.
- States:
  - IDLE: if `cache_cs`, go to COMPARE. Else if `flush_req`, go to FLUSH_SCAN with the scan counter at 0. `cache_cs` has priority over `flush_req`.
  - COMPARE: on a hit in any way, a read returns the word, a write merges the word and sets dirty, `cache_ack` pulses, and the state goes to IDLE. On a miss, the victim is the lowest-index invalid way, or the victim pointer if all ways are valid. A dirty victim goes to WRITEBACK; otherwise the state goes to ALLOCATE.
  - WRITEBACK: `dram_we`=1, address = {victim tag, index, 0}. On `dram_ack`, clear dirty and go to ALLOCATE.
  - ALLOCATE: `dram_we`=0, line-aligned request address. On `dram_ack`, write the line, set valid, clear dirty, store the tag, increment the set's victim pointer (mod `WAYS`) if it was used, and return to COMPARE. COMPARE then hits.
  - FLUSH_SCAN: iterate over (set, way) pairs in set-major order, one per cycle. For each dirty line, go to FLUSH_WB. After the last pair, pulse `flush_done` and go to IDLE.
  - FLUSH_WB: write the line back and, on `dram_ack`, clear dirty and resume the scan. Lines stay valid.
- The victim pointer changes only on a fill into a full set.
- `cache_cs` arriving during a flush is held off until after `flush_done`.

## Timing
- Reset: all valid/dirty bits, victim pointers and the scan counter clear; state = IDLE; `cache_ack`, `flush_done`, `dram_cs` and `dram_we` = 0; `dram_addr`, `dram_data_o` and `cache_data_o` = 0.
- Hit latency: `cache_ack` rises on the 2nd edge after `cache_cs` is sampled high in IDLE (IDLE→COMPARE→ack).
- Clean miss: ack comes 2 cycles after `dram_ack`. Dirty miss adds one full external transaction.
- `dram_cs` asserts the cycle after entry to WRITEBACK, ALLOCATE or FLUSH_WB, and deasserts the cycle after `dram_ack`. Address, we and data are stable throughout the request.
- `dram_ack` while `dram_cs`=0 is ignored.
- Reset mid-transaction: abandon the transaction, and `dram_cs` is 0 on the next cycle. A half-finished fill leaves the line invalid.
- Clean flush with no dirty lines: `flush_done` pulses `SETS*WAYS`+1 cycles after `flush_req` is sampled.

## Structure
- Package `l1_cache_pkg`: state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB) and helper functions for the derived OFF/IDX/TAG widths.
- Sub-module `l1_way_array`, instantiated `WAYS` times. Each instance holds the tag, valid, dirty and data arrays for `SETS` entries, with a combinational read and a synchronous write that has per-word and whole-line enables.
- The top level contains the FSM, hit detection, victim pointers and the flush counter.

## Test plan
Defaults throughout: `SETS`=32, `WAYS`=2, `LINE_W`=256, index = addr[9:5].
- Cold read of 0x0000_0048 → one `dram_cs` with `dram_addr`=0x40 and `dram_we`=0. Return a line whose word 2 is 0x1234_5678 → `cache_ack` with `cache_data_o`=0x1234_5678.
- Read of 0x4C after that fill → `cache_ack` 2 cycles after `cache_cs`, with no `dram_cs` activity.
- Write 0xDEAD_BEEF to 0x40, read 0x440 (fills way 1), then read 0x840 → write-back to `dram_addr` 0x40 with `dram_data_o`[31:0]=0xDEAD_BEEF, followed by a fill of 0x840.
- Dirty lines at 0x40 and 0x460, then `flush_req` → exactly two write-backs (0x40, then 0x460), then a `flush_done` pulse. A later read of 0x40 hits.
- `cache_cs` and `flush_req` asserted in the same cycle → the access acks first, and the flush starts afterwards.
- Assert `rst` while ALLOCATE is waiting on `dram_ack` → `dram_cs` is 0 the next cycle. A re-read of the same address misses and fills again.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared types and address-split helpers for the N-way L1 data cache
// Purpose: FSM state encoding and derived field widths (line offset, set index, tag).
// Ports: none (package).
package l1_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  // Byte-offset bits within a line.
  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Set-index bits.
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: whatever remains of the byte address above offset and index.
  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - off_w(line_w) - idx_w(sets);
  endfunction

endpackage

// File: rtl/l1_way_array.sv
// rtl/l1_way_array.sv - one way of the cache: valid/dirty/tag/data storage for every set
// Purpose: combinational read of the addressed set; synchronous write with a whole-line
//   fill port (sets valid, clears dirty) and a single-word merge port (sets dirty).
// Ports: clk, rst (sync, active-high, clears valid/dirty); idx selects the set for both
//   read and write; valid/dirty/tag/line are the read data; line_we/line_tag/line_data
//   fill a line; word_we/word_sel/word_data merge one word; dirty_clr clears dirty.
module l1_way_array #(
  parameter int SETS   = 32,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int TAG_W  = 22
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(SETS)-1:0]         idx,
  output logic                            valid,
  output logic                            dirty,
  output logic [TAG_W-1:0]                tag,
  output logic [LINE_W-1:0]               line,
  input  logic                            line_we,
  input  logic [TAG_W-1:0]                line_tag,
  input  logic [LINE_W-1:0]               line_data,
  input  logic                            word_we,
  input  logic [$clog2(LINE_W/WORD_W)-1:0] word_sel,
  input  logic [WORD_W-1:0]               word_data,
  input  logic                            dirty_clr
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end else if (dirty_clr) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // Tag and data need no reset: they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= line_tag;
      data_q[idx] <= line_data;
    end else if (word_we) begin
      data_q[idx][int'(word_sel)*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/l1_dcache_nway.sv
// rtl/l1_dcache_nway.sv - N-way set-associative write-back/write-allocate L1 data cache
// Purpose: FSM, hit detection, round-robin victim pointers and flush scan around WAYS
//   instances of l1_way_array.
// Ports: clk, rst (sync, active-high); CPU side cache_addr/cache_cs/cache_we/cache_data_i
//   in, cache_data_o/cache_ack out; flush_req in, flush_done out; memory side
//   dram_addr/dram_cs/dram_we/dram_data_o out, dram_data_i/dram_ack in.
module l1_dcache_nway
  import l1_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_cs,
  input  logic              cache_we,
  input  logic [WORD_W-1:0] cache_data_i,
  output logic [WORD_W-1:0] cache_data_o,
  output logic              cache_ack,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_cs,
  output logic              dram_we,
  output logic [LINE_W-1:0] dram_data_o,
  input  logic [LINE_W-1:0] dram_data_i,
  input  logic              dram_ack
);

  localparam int OFF    = off_w(LINE_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WSEL_W = OFF - 2;
  localparam int WAYL   = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? WAYL : 1;
  localparam int PAIRS  = SETS * WAYS;
  localparam int CNT_W  = $clog2(PAIRS) + 1;

  state_t state, next_state;

  logic [WSEL_W-1:0] a_word;
  logic [IDX_W-1:0]  a_idx, idx, scan_set;
  logic [TAG_W-1:0]  a_tag;
  logic              addr_unused;

  assign a_word      = cache_addr[OFF-1:2];
  assign a_idx       = cache_addr[OFF+IDX_W-1:OFF];
  assign a_tag       = cache_addr[ADDR_W-1:OFF+IDX_W];
  assign addr_unused = ^cache_addr[1:0];

  // Scan counter walks (set, way) pairs set-major; the extra value PAIRS is the
  // terminal cycle that raises flush_done.
  logic [CNT_W-1:0] cnt;
  logic [WAY_W-1:0] scan_way;
  logic             scan_last;

  assign scan_set  = IDX_W'(cnt >> WAYL);
  assign scan_way  = WAY_W'(cnt & CNT_W'(WAYS - 1));
  assign scan_last = (cnt == CNT_W'(PAIRS));

  logic in_flush;
  assign in_flush = (state == FLUSH_SCAN) || (state == FLUSH_WB);
  assign idx      = in_flush ? scan_set : a_idx;

  logic [WAYS-1:0]   rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag  [WAYS];
  logic [LINE_W-1:0] rd_line [WAYS];
  logic [WAYS-1:0]   line_we, word_we, dirty_clr;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    l1_way_array #(
      .SETS(SETS), .LINE_W(LINE_W), .WORD_W(WORD_W), .TAG_W(TAG_W)
    ) u_way (
      .clk(clk), .rst(rst), .idx(idx),
      .valid(rd_valid[w]), .dirty(rd_dirty[w]), .tag(rd_tag[w]), .line(rd_line[w]),
      .line_we(line_we[w]), .line_tag(a_tag), .line_data(dram_data_i),
      .word_we(word_we[w]), .word_sel(a_word), .word_data(cache_data_i),
      .dirty_clr(dirty_clr[w])
    );
  end

  logic [WAY_W-1:0] vptr [SETS];
  logic [WAY_W-1:0] vway;
  logic             use_ptr;

  logic [WAYS-1:0]  hit;
  logic [WAY_W-1:0] hit_way, inv_way, miss_way;
  logic             any_inv;

  // Descending loop so the lowest-index invalid way wins.
  always_comb begin
    hit     = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit[w] = rd_valid[w] && (rd_tag[w] == a_tag);
      if (hit[w]) hit_way = WAY_W'(w);
      if (!rd_valid[w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign miss_way = any_inv ? inv_way : vptr[a_idx];

  logic dram_fire;
  assign dram_fire = dram_cs && dram_ack;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // IDLE ignores requests during the ack / flush_done cycle, when the requester
  // has not yet had a chance to drop its level.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (!cache_ack && !flush_done) begin
                    if (cache_cs)       next_state = COMPARE;
                    else if (flush_req) next_state = FLUSH_SCAN;
                  end
      COMPARE:    if (|hit)                    next_state = IDLE;
                  else if (rd_dirty[miss_way]) next_state = WRITEBACK;
                  else                         next_state = ALLOCATE;
      WRITEBACK:  if (dram_fire) next_state = ALLOCATE;
      ALLOCATE:   if (dram_fire) next_state = COMPARE;
      FLUSH_SCAN: if (scan_last)               next_state = IDLE;
                  else if (rd_dirty[scan_way]) next_state = FLUSH_WB;
      FLUSH_WB:   if (dram_fire) next_state = FLUSH_SCAN;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    line_we   = '0;
    word_we   = '0;
    dirty_clr = '0;
    case (state)
      COMPARE:             if (cache_we) word_we = hit;
      WRITEBACK, FLUSH_WB: if (dram_fire) dirty_clr[vway] = 1'b1;
      ALLOCATE:            if (dram_fire) line_we[vway] = 1'b1;
      default: ;
    endcase
  end

  logic [ADDR_W-1:0] req_addr;
  assign req_addr = (state == ALLOCATE) ? {a_tag, idx, {OFF{1'b0}}}
                                        : {rd_tag[vway], idx, {OFF{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      cache_ack    <= 1'b0;
      flush_done   <= 1'b0;
      cache_data_o <= '0;
      dram_cs      <= 1'b0;
      dram_we      <= 1'b0;
      dram_addr    <= '0;
      dram_data_o  <= '0;
      vway         <= '0;
      use_ptr      <= 1'b0;
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
    end else begin
      cache_ack  <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: cnt <= '0;
        COMPARE: begin
          if (|hit) begin
            cache_ack <= 1'b1;
            if (!cache_we) cache_data_o <= rd_line[hit_way][int'(a_word)*WORD_W +: WORD_W];
          end else begin
            vway    <= miss_way;
            use_ptr <= !any_inv;
          end
        end
        WRITEBACK, ALLOCATE, FLUSH_WB: begin
          // Request is launched one cycle after entry and held until acked.
          if (!dram_cs) begin
            dram_cs     <= 1'b1;
            dram_we     <= (state != ALLOCATE);
            dram_addr   <= req_addr;
            dram_data_o <= rd_line[vway];
          end else if (dram_ack) begin
            dram_cs <= 1'b0;
            dram_we <= 1'b0;
            if (state == ALLOCATE && use_ptr)
              vptr[a_idx] <= WAY_W'((int'(vptr[a_idx]) + 1) % WAYS);
          end
        end
        FLUSH_SCAN: begin
          // A dirty pair is revisited after its write-back and then found clean.
          if (scan_last)               flush_done <= 1'b1;
          else if (rd_dirty[scan_way]) vway <= scan_way;
          else                         cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache_nway.sv
// tb/tb_l1_dcache_nway.sv - self-checking bench for l1_dcache_nway
// Purpose: directed table of accesses/flushes with fixed expectations, hand sequences for
//   request/flush priority and reset mid-fill, then randomized traffic against a model.
// Ports: none (top-level bench).
module tb_l1_dcache_nway;

  localparam int SETS = 32, WAYS = 2, LINE_W = 256;
  localparam int PAIRS = SETS * WAYS;
  localparam int OP_RD = 0, OP_WR = 1, OP_FL = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cache_addr, cache_data_i, cache_data_o, dram_addr;
  logic              cache_cs, cache_we, cache_ack, flush_req, flush_done;
  logic              dram_cs, dram_we, dram_ack;
  logic [LINE_W-1:0] dram_data_o, dram_data_i;

  always #5 clk = ~clk;

  l1_dcache_nway #(.ADDR_W(32), .WORD_W(32), .LINE_W(LINE_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .cache_addr(cache_addr), .cache_cs(cache_cs), .cache_we(cache_we),
    .cache_data_i(cache_data_i), .cache_data_o(cache_data_o), .cache_ack(cache_ack),
    .flush_req(flush_req), .flush_done(flush_done), .dram_addr(dram_addr), .dram_cs(dram_cs),
    .dram_we(dram_we), .dram_data_o(dram_data_o), .dram_data_i(dram_data_i), .dram_ack(dram_ack)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] w0; } txn_t;
  typedef struct {
    int op; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp_data;
    int exp_fills; int exp_wbs;
    logic [31:0] wb_addr0; logic [31:0] wb_w0; logic [31:0] wb_addr1; logic [31:0] wb_w1;
  } vec_t;

  int n_vec = 0, n_err = 0;
  txn_t txq[$];
  logic [LINE_W-1:0] dram_mem [logic [31:0]];
  logic [31:0]       ref_mem  [logic [31:0]];
  int dly = 0;
  bit rand_dly = 0, stray_en = 0;

  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [31:0] m_line  [SETS][WAYS];
  int          m_ptr   [SETS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h48) return 32'h1234_5678;
    return a ^ 32'hA500_0000;
  endfunction

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    if (dram_mem.exists(la)) return dram_mem[la];
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Cache behaviour from the rules: lines identified by line address, set = line % SETS.
  function automatic void model_access(input logic [31:0] a, input bit we,
                                       output int fills, output int wbs, output logic [31:0] wb_addr);
    logic [31:0] la;
    int s, h, v;
    la = a & ~32'h1F;
    s = int'((a >> 5) % SETS);
    h = -1;
    fills = 0; wbs = 0; wb_addr = '0;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_line[s][w] == la) h = w;
    if (h < 0) begin
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
      if (v < 0) begin v = m_ptr[s]; m_ptr[s] = (m_ptr[s] + 1) % WAYS; end
      if (m_valid[s][v] && m_dirty[s][v]) begin wbs = 1; wb_addr = m_line[s][v]; end
      fills = 1;
      m_valid[s][v] = 1; m_dirty[s][v] = 0; m_line[s][v] = la;
      h = v;
    end
    if (we) begin
      m_dirty[s][h] = 1;
      ref_mem[a & ~32'h3] = 32'h0;
    end
  endfunction

  function automatic int model_flush();
    int n = 0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin n++; m_dirty[s][w] = 0; end
    return n;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
    end
  endfunction

  // External memory responder, called once per negedge.
  task automatic dram_service();
    if (dram_cs) begin
      if (dly > 0) begin
        dly--;
        dram_ack = 1'b0;
      end else begin
        check("dram_addr_aligned", dram_addr[4:0], 5'd0);
        txq.push_back('{dram_we, dram_addr, dram_data_o[31:0]});
        if (dram_we) dram_mem[dram_addr] = dram_data_o;
        else         dram_data_i = line_of(dram_addr);
        dram_ack = 1'b1;
        dly = rand_dly ? int'($urandom_range(0, 3)) : 0;
      end
    end else begin
      dram_ack = stray_en && ($urandom_range(0, 7) == 0);
    end
  endtask

  function automatic int count_we(input bit we);
    int n = 0;
    foreach (txq[i]) if (txq[i].we == we) n++;
    return n;
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    dram_service();
  endtask

  task automatic op_access(input logic [31:0] a, input bit we, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
    bit got = 0;
    txq.delete();
    cache_addr = a; cache_we = we; cache_data_i = wd; cache_cs = 1'b1;
    lat = 0; rd = '0;
    while (!got && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (cache_ack) begin got = 1; rd = cache_data_o; cache_cs = 1'b0; end
      dram_service();
    end
    cache_cs = 1'b0;
    check("ack_seen", got, 1'b1);
    idle_cycle();
    check("ack_one_cycle", cache_ack, 1'b0);
    if (we) ref_mem[a & ~32'h3] = wd;
  endtask

  task automatic op_flush(output int lat);
    bit got = 0;
    txq.delete();
    flush_req = 1'b1;
    lat = 0;
    while (!got && lat < 5000) begin
      @(negedge clk);
      lat++;
      if (flush_done) begin got = 1; flush_req = 1'b0; end
      dram_service();
    end
    flush_req = 1'b0;
    check("flush_done_seen", got, 1'b1);
    idle_cycle();
    check("flush_done_one_cycle", flush_done, 1'b0);
  endtask

  vec_t tbl[12];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, pwb_addr;
    int lat, pf, pw, ack_c, dcs_c, done_c, c;

    rst = 1'b1; cache_addr = '0; cache_cs = 0; cache_we = 0; cache_data_i = '0;
    flush_req = 0; dram_ack = 0; dram_data_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cache_ack", cache_ack, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_dram_cs", dram_cs, 1'b0);
    check("rst_dram_we", dram_we, 1'b0);
    check("rst_dram_addr", dram_addr, 32'h0);
    check("rst_dram_data_o", (dram_data_o == '0), 1'b1);
    check("rst_cache_data_o", cache_data_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // op, addr, wdata, exp_data, fills, wbs, wb_addr0, wb_w0, wb_addr1, wb_w1
    tbl[0]  = '{OP_RD, 32'h048, 32'h0,         32'h1234_5678, 1, 0, 0,      0,             0,       0};
    tbl[1]  = '{OP_RD, 32'h04C, 32'h0,         32'hA500_004C, 0, 0, 0,      0,             0,       0};
    tbl[2]  = '{OP_WR, 32'h040, 32'hDEAD_BEEF, 32'h0,         0, 0, 0,      0,             0,       0};
    tbl[3]  = '{OP_RD, 32'h440, 32'h0,         32'hA500_0440, 1, 0, 0,      0,             0,       0};
    tbl[4]  = '{OP_RD, 32'h840, 32'h0,         32'hA500_0840, 1, 1, 32'h40, 32'hDEAD_BEEF, 0,       0};
    tbl[5]  = '{OP_WR, 32'h460, 32'h1111_2222, 32'h0,         1, 0, 0,      0,             0,       0};
    tbl[6]  = '{OP_WR, 32'h040, 32'hCAFE_F00D, 32'h0,         1, 0, 0,      0,             0,       0};
    tbl[7]  = '{OP_FL, 32'h0,   32'h0,         32'h0,         0, 2, 32'h40, 32'hCAFE_F00D, 32'h460, 32'h1111_2222};
    tbl[8]  = '{OP_RD, 32'h040, 32'h0,         32'hCAFE_F00D, 0, 0, 0,      0,             0,       0};
    tbl[9]  = '{OP_RD, 32'h048, 32'h0,         32'h1234_5678, 0, 0, 0,      0,             0,       0};
    tbl[10] = '{OP_FL, 32'h0,   32'h0,         32'h0,         0, 0, 0,      0,             0,       0};
    tbl[11] = '{OP_RD, 32'h460, 32'h0,         32'h1111_2222, 0, 0, 0,      0,             0,       0};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].op == OP_FL) begin
        pw = model_flush();
        op_flush(lat);
        if (tbl[i].exp_wbs == 0) check("clean_flush_latency", lat, PAIRS + 2);
      end else begin
        model_access(tbl[i].addr, tbl[i].op == OP_WR, pf, pw, pwb_addr);
        op_access(tbl[i].addr, tbl[i].op == OP_WR, tbl[i].wdata, rd, lat);
        if (tbl[i].op == OP_RD) check("vec_rdata", rd, tbl[i].exp_data);
        if (tbl[i].exp_fills + tbl[i].exp_wbs == 0) check("vec_hit_latency", lat, 2);
      end
      check("vec_fills", count_we(1'b0), tbl[i].exp_fills);
      check("vec_wbs", count_we(1'b1), tbl[i].exp_wbs);
      if (tbl[i].exp_wbs >= 1 && txq.size() >= 1) begin
        check("vec_wb0_first", txq[0].we, 1'b1);
        check("vec_wb0_addr", txq[0].addr, tbl[i].wb_addr0);
        check("vec_wb0_word0", txq[0].w0, tbl[i].wb_w0);
      end
      if (tbl[i].exp_wbs >= 2 && txq.size() >= 2) begin
        check("vec_wb1_addr", txq[1].addr, tbl[i].wb_addr1);
        check("vec_wb1_word0", txq[1].w0, tbl[i].wb_w1);
      end
      if (tbl[i].exp_fills == 1 && txq.size() >= 1)
        check("vec_fill_addr", txq[txq.size()-1].addr, tbl[i].addr & ~32'h1F);
    end

    // Simultaneous request and flush: the access completes before any flush traffic.
    model_access(32'h80, 1'b1, pf, pw, pwb_addr);
    op_access(32'h80, 1'b1, 32'h0BAD_F00D, rd, lat);
    txq.delete();
    cache_addr = 32'h80; cache_we = 1'b0; cache_cs = 1'b1; flush_req = 1'b1;
    ack_c = -1; dcs_c = -1; done_c = -1; c = 0;
    while (done_c < 0 && c < 1000) begin
      @(negedge clk);
      c++;
      if (cache_ack && ack_c < 0) begin ack_c = c; rd = cache_data_o; cache_cs = 1'b0; end
      if (dram_cs && dcs_c < 0) dcs_c = c;
      if (flush_done) begin done_c = c; flush_req = 1'b0; end
      dram_service();
    end
    cache_cs = 1'b0; flush_req = 1'b0;
    idle_cycle();
    pw = model_flush();
    check("prio_ack_latency", ack_c, 2);
    check("prio_rdata", rd, 32'h0BAD_F00D);
    check("prio_flush_after_ack", (dcs_c > ack_c) && (done_c > dcs_c), 1'b1);
    check("prio_wbs", count_we(1'b1), 1);
    if (txq.size() >= 1) check("prio_wb_addr", txq[0].addr, 32'h80);

    // Reset while a fill is outstanding.
    cache_addr = 32'hC00; cache_we = 1'b0; cache_cs = 1'b1;
    c = 0;
    while (!dram_cs && c < 100) begin @(negedge clk); c++; end
    check("rstmid_fill_started", dram_cs, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_dram_cs_low", dram_cs, 1'b0);
    check("rstmid_no_ack", cache_ack, 1'b0);
    rst = 1'b0; cache_cs = 1'b0;
    @(negedge clk);
    model_reset();
    model_access(32'hC00, 1'b0, pf, pw, pwb_addr);
    op_access(32'hC00, 1'b0, 32'h0, rd, lat);
    check("rstmid_refill", count_we(1'b0), 1);
    check("rstmid_rdata", rd, 32'hA500_0C00);

    // Randomized traffic against the model, with variable memory latency and stray acks.
    rand_dly = 1; stray_en = 1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, wd;
      bit we;
      if ($urandom_range(0, 19) == 0) begin
        pw = model_flush();
        op_flush(lat);
        check("rnd_flush_wbs", count_we(1'b1), pw);
        check("rnd_flush_fills", count_we(1'b0), 0);
      end else begin
        a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
           | (32'($urandom_range(0, 7)) << 2);
        we = $urandom_range(0, 1) == 1;
        wd = $urandom;
        model_access(a, we, pf, pw, pwb_addr);
        op_access(a, we, wd, rd, lat);
        if (!we) check("rnd_rdata", rd, ref_word(a));
        check("rnd_fills", count_we(1'b0), pf);
        check("rnd_wbs", count_we(1'b1), pw);
        if (pw == 1 && txq.size() >= 1) check("rnd_wb_addr", txq[0].addr, pwb_addr);
        if (pf + pw == 0) check("rnd_hit_latency", lat, 2);
      end
    end

    // After a final flush, memory must hold every word the CPU wrote.
    pw = model_flush();
    op_flush(lat);
    check("final_flush_wbs", count_we(1'b1), pw);
    foreach (ref_mem[k]) begin
      logic [LINE_W-1:0] l;
      l = line_of(k & ~32'h1F);
      check("coherent_word", l[int'(k[4:2])*32 +: 32], ref_mem[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
